// File: rtl/pe_array_sched_if.sv
// Host/array-side signal bundle for pe_array_sched.
// The master side is the layer controller or bench. The slave side is the scheduler.
interface pe_array_sched_if #(
    parameter int N_ROWS = 4,
    parameter int CNT_W  = 8
);
    localparam int RSW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    logic             start;
    logic [CNT_W-1:0] num_pix;
    logic [4:0]       exp_bias_cfg;
    logic             stall;
    logic             busy;
    logic             done;
    logic             err;
    logic             w_load_en;
    logic [RSW-1:0]   w_row_sel;
    logic             img_valid;
    logic [CNT_W-1:0] img_idx;
    logic             pe_en;
    logic             psum_valid_out;
    logic [4:0]       exp_bias_out;

    modport master (
        output start, num_pix, exp_bias_cfg, stall,
        input  busy, done, err, w_load_en, w_row_sel, img_valid, img_idx,
               pe_en, psum_valid_out, exp_bias_out
    );

    modport slave (
        input  start, num_pix, exp_bias_cfg, stall,
        output busy, done, err, w_load_en, w_row_sel, img_valid, img_idx,
               pe_en, psum_valid_out, exp_bias_out
    );
endinterface

// File: rtl/pe_array_sched.sv
// Job sequencer for the weight-stationary PE array: load weights, stream pixels,
// drain the skewed psum pipeline, then pulse done. All outputs are registered.
module pe_array_sched #(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    pe_array_sched_if.slave  bus
);
    localparam int LAT = N_ROWS + N_COLS - 1;
    localparam int RSW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // state_q/cnt_q name the item being worked on this cycle. When act_q is low,
    // the cycle was frozen and they name the item still pending.
    state_t           state_q, state_d, nxt_state;
    logic [CNT_W-1:0] cnt_q, cnt_d, nxt_cnt;
    logic             act_q, act_d;
    logic [CNT_W-1:0] num_pix_q, num_pix_d;
    logic [4:0]       exp_bias_q, exp_bias_d;
    logic [LAT-1:0]   line_q, line_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             w_load_en_q, w_load_en_d;
    logic [RSW-1:0]   w_row_sel_q, w_row_sel_d;
    logic             img_valid_q, img_valid_d;
    logic [CNT_W-1:0] img_idx_q, img_idx_d;
    logic             pe_en_q, pe_en_d;
    logic             psum_valid_q, psum_valid_d;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no latch is inferred.
        nxt_state    = state_q;
        nxt_cnt      = cnt_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_d        = 1'b0;
        num_pix_d    = num_pix_q;
        exp_bias_d   = exp_bias_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        w_load_en_d  = 1'b0;
        w_row_sel_d  = '0;
        img_valid_d  = 1'b0;
        img_idx_d    = '0;
        pe_en_d      = 1'b0;

        if (act_q) begin
            case (state_q)
                S_LOAD_W: begin
                    if (cnt_q == CNT_W'(N_ROWS - 1)) begin
                        nxt_state = S_STREAM;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (cnt_q == num_pix_q - CNT_W'(1)) begin
                        nxt_state = S_DRAIN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == CNT_W'(LAT - 1)) begin
                        nxt_state = S_DONE;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end
                default: ;
            endcase
        end

        if (state_q == S_IDLE && bus.start) begin
            if (bus.num_pix == '0) begin
                err_d = 1'b1;
            end else begin
                nxt_state  = S_LOAD_W;
                nxt_cnt    = '0;
                num_pix_d  = bus.num_pix;
                exp_bias_d = bus.exp_bias_cfg;
            end
        end

        state_d = nxt_state;
        cnt_d   = nxt_cnt;
        busy_d  = (nxt_state != S_IDLE);

        if (nxt_state inside {S_LOAD_W, S_STREAM, S_DRAIN}) begin
            act_d = !bus.stall;
            if (act_d) begin
                case (nxt_state)
                    S_LOAD_W: begin
                        w_load_en_d = 1'b1;
                        w_row_sel_d = nxt_cnt[RSW-1:0];
                    end
                    S_STREAM: begin
                        img_valid_d = 1'b1;
                        img_idx_d   = nxt_cnt;
                        pe_en_d     = 1'b1;
                    end
                    default: pe_en_d = 1'b1;
                endcase
            end
        end else if (nxt_state == S_DONE) begin
            act_d  = 1'b1;
            done_d = 1'b1;
        end

        // The line shifts on the edge that closes each pe_en cycle.
        line_d       = pe_en_q ? {line_q[LAT-2:0], img_valid_q} : line_q;
        psum_valid_d = line_d[LAT-1] & pe_en_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            act_q        <= 1'b0;
            num_pix_q    <= '0;
            exp_bias_q   <= '0;
            // NOTE: the delay line is cleared. A stale bit would show up as a
            // phantom psum_valid_out on the next job.
            line_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            w_load_en_q  <= 1'b0;
            w_row_sel_q  <= '0;
            img_valid_q  <= 1'b0;
            img_idx_q    <= '0;
            pe_en_q      <= 1'b0;
            psum_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            num_pix_q    <= num_pix_d;
            exp_bias_q   <= exp_bias_d;
            line_q       <= line_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            w_load_en_q  <= w_load_en_d;
            w_row_sel_q  <= w_row_sel_d;
            img_valid_q  <= img_valid_d;
            img_idx_q    <= img_idx_d;
            pe_en_q      <= pe_en_d;
            psum_valid_q <= psum_valid_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.w_load_en      = w_load_en_q;
    assign bus.w_row_sel      = w_row_sel_q;
    assign bus.img_valid      = img_valid_q;
    assign bus.img_idx        = img_idx_q;
    assign bus.pe_en          = pe_en_q;
    assign bus.psum_valid_out = psum_valid_q;
    assign bus.exp_bias_out   = exp_bias_q;
endmodule

// File: tb/tb_pe_array_sched.sv
// Scoreboard bench for pe_array_sched (N_ROWS=N_COLS=4, LAT=7).
// Stimulus pushes expected strobe events. A negedge monitor pops and compares them.
module tb_pe_array_sched;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int CNT_W  = 8;
    localparam int LAT    = N_ROWS + N_COLS - 1;

    localparam int K_WL = 0, K_IMG = 1, K_PS = 2, K_DONE = 3, K_ERR = 4, K_BUSY = 5;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    bit   mon_en;
    logic busy_prev;

    ev_t q_wl[$], q_img[$], q_ps[$], q_done[$], q_err[$], q_busy[$];

    pe_array_sched_if #(.N_ROWS(N_ROWS), .CNT_W(CNT_W)) bus ();

    pe_array_sched #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int k, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        case (k)
            K_WL:    q_wl.push_back(e);
            K_IMG:   q_img.push_back(e);
            K_PS:    q_ps.push_back(e);
            K_DONE:  q_done.push_back(e);
            K_ERR:   q_err.push_back(e);
            default: q_busy.push_back(e);
        endcase
    endfunction

    task automatic pop_cmp(input int k, input logic [31:0] v);
        ev_t   e;
        int    sz;
        string nm;
        sz = 0;
        case (k)
            K_WL:    begin nm = "w_load_en";      sz = q_wl.size();   if (sz > 0) e = q_wl.pop_front();   end
            K_IMG:   begin nm = "img_valid";      sz = q_img.size();  if (sz > 0) e = q_img.pop_front();  end
            K_PS:    begin nm = "psum_valid_out"; sz = q_ps.size();   if (sz > 0) e = q_ps.pop_front();   end
            K_DONE:  begin nm = "done";           sz = q_done.size(); if (sz > 0) e = q_done.pop_front(); end
            K_ERR:   begin nm = "err";            sz = q_err.size();  if (sz > 0) e = q_err.pop_front();  end
            default: begin nm = "busy edge";      sz = q_busy.size(); if (sz > 0) e = q_busy.pop_front(); end
        endcase
        if (sz == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s unexpected: got event value %0d at cycle %0d, required none", nm, v, cyc);
        end else begin
            check({nm, " cycle"}, cyc, e.cyc);
            check({nm, " value"}, v, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.w_load_en === 1'b1)      pop_cmp(K_WL, 32'(bus.w_row_sel));
            if (bus.img_valid === 1'b1)      pop_cmp(K_IMG, 32'(bus.img_idx));
            if (bus.psum_valid_out === 1'b1) pop_cmp(K_PS, 0);
            if (bus.done === 1'b1)           pop_cmp(K_DONE, 0);
            if (bus.err === 1'b1)            pop_cmp(K_ERR, 0);
            if (bus.busy !== busy_prev)      pop_cmp(K_BUSY, 32'(bus.busy));
            busy_prev = bus.busy;
        end
    end

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_start(input int np, input int eb);
        bus.start        = 1'b1;
        bus.num_pix      = CNT_W'(np);
        bus.exp_bias_cfg = 5'(eb);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Unstalled job whose start is driven in cycle t0.
    task automatic expect_job(input int t0, input int np);
        for (int r = 0; r < N_ROWS; r++) push(K_WL, t0 + 1 + r, r);
        for (int i = 0; i < np; i++) begin
            push(K_IMG, t0 + N_ROWS + 1 + i, i);
            push(K_PS, t0 + N_ROWS + LAT + 1 + i, 0);
        end
        push(K_DONE, t0 + N_ROWS + np + LAT + 1, 0);
        push(K_BUSY, t0 + 1, 1);
        push(K_BUSY, t0 + N_ROWS + np + LAT + 2, 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, " w_load_en pending"}, q_wl.size(), 0);
        check({tag, " img_valid pending"}, q_img.size(), 0);
        check({tag, " psum_valid pending"}, q_ps.size(), 0);
        check({tag, " done pending"}, q_done.size(), 0);
        check({tag, " err pending"}, q_err.size(), 0);
        check({tag, " busy pending"}, q_busy.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(bus.busy), 0);
        check({tag, " done"}, 32'(bus.done), 0);
        check({tag, " err"}, 32'(bus.err), 0);
        check({tag, " w_load_en"}, 32'(bus.w_load_en), 0);
        check({tag, " w_row_sel"}, 32'(bus.w_row_sel), 0);
        check({tag, " img_valid"}, 32'(bus.img_valid), 0);
        check({tag, " img_idx"}, 32'(bus.img_idx), 0);
        check({tag, " pe_en"}, 32'(bus.pe_en), 0);
        check({tag, " psum_valid_out"}, 32'(bus.psum_valid_out), 0);
        check({tag, " exp_bias_out"}, 32'(bus.exp_bias_out), 0);
    endtask

    initial begin
        int t0;
        n_vec            = 0;
        n_err            = 0;
        mon_en           = 1'b0;
        busy_prev        = 1'b0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.num_pix      = '0;
        bus.exp_bias_cfg = '0;
        bus.stall        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;
        to_cycle(cyc + 2);

        // 1: num_pix=3, no stall
        t0 = cyc;
        expect_job(t0, 3);
        issue_start(3, 19);
        to_cycle(t0 + 20);
        check("t1 exp_bias_out", 32'(bus.exp_bias_out), 19);
        check_drained("t1");

        // 2: num_pix=3; stall is sampled on the closing edge, so it is driven in
        // cycles 5 and 13 to freeze output cycles 6 and 14.
        t0 = cyc;
        for (int r = 0; r < 4; r++) push(K_WL, t0 + 1 + r, r);
        push(K_IMG, t0 + 5, 0);
        push(K_IMG, t0 + 7, 1);
        push(K_IMG, t0 + 8, 2);
        push(K_PS, t0 + 13, 0);
        push(K_PS, t0 + 15, 0);
        push(K_PS, t0 + 16, 0);
        push(K_DONE, t0 + 17, 0);
        push(K_BUSY, t0 + 1, 1);
        push(K_BUSY, t0 + 18, 0);
        issue_start(3, 7);
        to_cycle(t0 + 5);  bus.stall = 1'b1;
        to_cycle(t0 + 6);  bus.stall = 1'b0;
        check("t2 pe_en frozen @6", 32'(bus.pe_en), 0);
        to_cycle(t0 + 13); bus.stall = 1'b1;
        to_cycle(t0 + 14); bus.stall = 1'b0;
        check("t2 pe_en frozen @14", 32'(bus.pe_en), 0);
        check("t2 busy while frozen", 32'(bus.busy), 1);
        to_cycle(t0 + 22);
        check_drained("t2");

        // 3: num_pix=0 gives an err pulse only
        t0 = cyc;
        push(K_ERR, t0 + 1, 0);
        issue_start(0, 3);
        check("t3 busy @1", 32'(bus.busy), 0);
        to_cycle(t0 + 5);
        check_drained("t3");

        // 4: start re-pulsed during the job is ignored
        t0 = cyc;
        expect_job(t0, 3);
        issue_start(3, 11);
        to_cycle(t0 + 5); issue_start(9, 2);
        to_cycle(t0 + 9); issue_start(9, 2);
        check("t4 exp_bias_out mid-job", 32'(bus.exp_bias_out), 11);
        to_cycle(t0 + 20);
        check("t4 exp_bias_out after", 32'(bus.exp_bias_out), 11);
        check_drained("t4");

        // 5: rst driven in cycle 6 aborts the job; a new job starts in cycle 8
        t0 = cyc;
        for (int r = 0; r < 4; r++) push(K_WL, t0 + 1 + r, r);
        push(K_IMG, t0 + 5, 0);
        push(K_IMG, t0 + 6, 1);
        push(K_BUSY, t0 + 1, 1);
        push(K_BUSY, t0 + 7, 0);
        issue_start(3, 9);
        to_cycle(t0 + 6); rst = 1'b1;
        to_cycle(t0 + 7); rst = 1'b0;
        check_all_zero("t5 after rst");
        to_cycle(t0 + 8);
        expect_job(t0 + 8, 1);
        issue_start(1, 4);
        to_cycle(t0 + 20);
        check("t5 done not yet @20", 32'(bus.done), 0);
        to_cycle(t0 + 21);
        check("t5 done @21", 32'(bus.done), 1);
        to_cycle(t0 + 25);
        check_drained("t5");

        // 6: maximum count must not wrap
        t0 = cyc;
        expect_job(t0, 255);
        issue_start(255, 31);
        to_cycle(t0 + 271);
        check("t6 exp_bias_out", 32'(bus.exp_bias_out), 31);
        check_drained("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
